// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: command and FSM state encodings shared by the alu_seq block.
package alu_seq_pkg;

    localparam int ALU_CMD_W = 4;

    typedef enum logic [ALU_CMD_W-1:0] {
        OP_ADD, OP_SUB, OP_ADC, OP_PASSA, OP_PASSB, OP_NOR, OP_XOR, OP_AND,
        OP_OR, OP_SLL, OP_SRL, OP_EQ, OP_LT, OP_RXOR, OP_MUL, OP_RSVD
    } alu_op_t;

    typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} alu_state_t;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/command handshake in, result/flag handshake out.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic [alu_seq_pkg::ALU_CMD_W-1:0] alu_cmd;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic sc_i;
    logic in_valid;
    logic in_ready;
    logic [WIDTH-1:0] rslt;
    logic sc_o;
    logic pari;
    logic one;
    logic zero;
    logic out_valid;
    logic out_ready;

    modport master (
        output alu_cmd, inA, inB, sc_i, in_valid, out_ready,
        input  in_ready, rslt, sc_o, pari, one, zero, out_valid
    );

    modport slave (
        input  alu_cmd, inA, inB, sc_i, in_valid, out_ready,
        output in_ready, rslt, sc_o, pari, one, zero, out_valid
    );
endinterface

// File: rtl/alu_seq_shmul.sv
// alu_seq_shmul: iterative one-bit shifter and shift-add multiplier; the load cycle already performs the first step.
// ALU_SEQ_MUL_EN builds the multiplier datapath; without it only the shifter exists.
module alu_seq_shmul #(
    parameter int WIDTH = 8,
    parameter int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             mul,
    input  logic             left,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             co,
    output logic             done
);
    localparam int CW = SHW + 1;

    logic [WIDTH-1:0] lo, src_lo, sh_lo;
    logic [CW-1:0] cnt, src_cnt, nxt_cnt;
    logic left_q, src_left, sh_co;

    assign src_left = load ? left : left_q;
    assign src_lo = load ? (mul ? b : a) : lo;
    assign src_cnt = load ? (mul ? CW'(WIDTH) : CW'(b[SHW-1:0])) : cnt;
    assign nxt_cnt = src_cnt - CW'(1);
    // done marks that the step taken this cycle is the final one
    assign done = nxt_cnt == '0;
    assign sh_lo = src_left ? src_lo << 1 : src_lo >> 1;
    assign sh_co = src_left ? src_lo[WIDTH-1] : src_lo[0];

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] hi, mc, src_hi, src_mc;
    logic [WIDTH:0] sum;
    logic mul_q, src_mul;

    assign src_mul = load ? mul : mul_q;
    assign src_hi = load ? '0 : hi;
    assign src_mc = load ? a : mc;
    // {hi, lo} holds the partial product; the multiplier drains out of lo
    assign sum = {1'b0, src_hi} + {1'b0, src_lo[0] ? src_mc : {WIDTH{1'b0}}};
    assign res = src_mul ? {sum[0], src_lo[WIDTH-1:1]} : sh_lo;
    assign co = src_mul ? |sum[WIDTH:1] : sh_co;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            hi <= '0;
            mc <= '0;
            mul_q <= 1'b0;
        end else begin
            if (load | step) hi <= sum[WIDTH:1];
            if (load) begin
                mc <= a;
                mul_q <= mul;
            end
        end
`else
    assign res = sh_lo;
    assign co = sh_co;
`endif

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            lo <= '0;
            cnt <= '0;
            left_q <= 1'b0;
        end else begin
            if (load | step) begin
                lo <= res;
                cnt <= nxt_cnt;
            end
            if (load) left_q <= left;
        end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle parametrised ALU with valid/ready on both sides and registered result/flags.
// Define ALU_SEQ_MUL_EN to build the shift-add multiplier (command E); otherwise E behaves as reserved.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW = $clog2(WIDTH)
) (
    input logic clk,
    input logic reset,
    alu_seq_if.slave bus
);
    alu_state_t state;
    alu_op_t op;
    logic [WIDTH-1:0] a, b, cres, eng_res, res_n, rslt;
    logic [WIDTH:0] sum, diff;
    logic cco, cone, co_n, one_n, sc, one, pari, zero;
    logic in_ready, acc_in, deg, is_shift, is_mul, eng_path, eng_load, eng_step, eng_busy, eng_done, eng_co, wr;

    assign op = alu_op_t'(bus.alu_cmd);
    assign a = bus.inA;
    assign b = bus.inB;
    assign in_ready = state == IDLE | (state == DONE & bus.out_ready);
    assign acc_in = bus.in_valid & in_ready;
    assign deg = b >= WIDTH'(WIDTH);
    assign is_shift = op == OP_SLL | op == OP_SRL;
`ifdef ALU_SEQ_MUL_EN
    assign is_mul = op == OP_MUL;
`else
    assign is_mul = 1'b0;
`endif
    assign eng_path = (is_shift & ~deg & b != '0) | is_mul;
    assign eng_load = acc_in & eng_path;
    assign eng_step = state == SHIFT | state == MUL;
    assign eng_busy = eng_load | eng_step;
    assign sum = {1'b0, a} + {1'b0, b} + (WIDTH + 1)'(op == OP_ADC & bus.sc_i);
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        cres = '0;
        cco = 1'b0;
        cone = 1'b0;
        case (op)
            OP_ADD, OP_ADC: {cco, cres} = sum;
            OP_SUB:         {cco, cres} = diff;
            OP_PASSA:       cres = a;
            OP_PASSB:       cres = b;
            OP_NOR:         cres = ~(a | b);
            OP_XOR:         cres = a ^ b;
            OP_AND:         cres = a & b;
            OP_OR:          cres = a | b;
            OP_SLL, OP_SRL: cres = deg ? '0 : a;
            OP_EQ:          cone = a == b;
            OP_LT:          cone = a < b;
            OP_RXOR:        cres = {{(WIDTH-1){1'b0}}, ^b};
            default:        ;
        endcase
        if (op == OP_EQ | op == OP_LT) cres = {{(WIDTH-1){1'b0}}, cone};
    end

    assign wr = (acc_in & ~eng_path) | (eng_busy & eng_done);
    assign res_n = eng_busy ? eng_res : cres;
    assign co_n = eng_busy ? eng_co : cco;
    assign one_n = eng_busy ? 1'b0 : cone;

    alu_seq_shmul #(.WIDTH(WIDTH), .SHW(SHW)) u_shmul (
        .clk(clk), .reset(reset), .load(eng_load), .step(eng_step), .mul(is_mul),
        .left(op == OP_SLL), .a(a), .b(b), .res(eng_res), .co(eng_co), .done(eng_done)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            rslt <= '0;
            sc <= 1'b0;
            one <= 1'b0;
            pari <= 1'b0;
            zero <= 1'b0;
        end else begin
            if (wr) begin
                rslt <= res_n;
                sc <= co_n;
                one <= one_n;
                pari <= ^res_n;
                zero <= res_n == '0;
            end
            state <= acc_in ? ((eng_path & ~eng_done) ? (is_mul ? MUL : SHIFT) : DONE)
                   : (eng_step & eng_done) ? DONE
                   : (state == DONE & bus.out_ready) ? IDLE : state;
        end

    assign bus.in_ready = in_ready;
    assign bus.out_valid = state == DONE;
    assign bus.rslt = rslt;
    assign bus.sc_o = sc;
    assign bus.one = one;
    assign bus.pari = pari;
    assign bus.zero = zero;
endmodule
